// File: rtl/lms_weight_update.sv
// LMS weight update: w[k] <= w[k] + mu * x[k] * econj, with the N_ELEM weights
// time-multiplexed through one three-stage complex multiply/accumulate pipeline.
module lms_weight_update #(
   parameter int N_ELEM   = 4,
   parameter int IDX_W    = 2,
   parameter int MU_SHIFT = 4,
   parameter int WINIT_I  = 65536,
   parameter int WINIT_Q  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sof,
   input  logic [17:0]      xI,
   input  logic [17:0]      xQ,
   input  logic [17:0]      econjI,
   input  logic [17:0]      econjQ,
   input  logic             adapt_en,
   input  logic             wclr,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic [17:0]      wI,
   output logic [17:0]      wQ,
   output logic             sat_flag
);

   localparam int                SHIFT    = 16 + MU_SHIFT;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);
   localparam logic signed [17:0] INIT_I  = 18'(WINIT_I);
   localparam logic signed [17:0] INIT_Q  = 18'(WINIT_Q);
   localparam logic signed [37:0] SAT_HI  = 38'sd131071;
   localparam logic signed [37:0] SAT_LO  = -38'sd131072;

   // Returns {clipped, value} for a wide sum clamped to the Q2.16 range.
   function automatic logic [18:0] saturate(input logic signed [37:0] v);
      if (v > SAT_HI) return {1'b1, 18'h1ffff};
      if (v < SAT_LO) return {1'b1, 18'h20000};
      return {1'b0, v[17:0]};
   endfunction

   logic [IDX_W-1:0]   cnt_q, cnt_d, beat_idx;

   logic               v1_q, v1_d, en1_q, en1_d;
   logic [IDX_W-1:0]   idx1_q, idx1_d;
   logic signed [35:0] p_ii_q, p_ii_d, p_qq_q, p_qq_d;
   logic signed [35:0] p_iq_q, p_iq_d, p_qi_q, p_qi_d;

   logic               v2_q, v2_d, en2_q, en2_d;
   logic [IDX_W-1:0]   idx2_q, idx2_d;
   logic signed [36:0] r_i_q, r_i_d, r_q_q, r_q_d;

   logic signed [17:0] w_i_q [N_ELEM];
   logic signed [17:0] w_i_d [N_ELEM];
   logic signed [17:0] w_q_q [N_ELEM];
   logic signed [17:0] w_q_d [N_ELEM];

   logic               ov_q, ov_d, osat_q, osat_d;
   logic [IDX_W-1:0]   oidx_q, oidx_d;
   logic [17:0]        owi_q, owi_d, owq_q, owq_d;

   logic signed [36:0] u_i, u_q;
   logic signed [37:0] sum_i, sum_q;
   logic signed [17:0] sat_i, sat_q;
   logic               clip_i, clip_q;

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      beat_idx = in_sof ? '0 : cnt_q;
      cnt_d    = cnt_q;
      if (in_valid) cnt_d = (beat_idx == LAST_IDX) ? '0 : beat_idx + IDX_W'(1);

      v1_d   = in_valid;
      idx1_d = beat_idx;
      en1_d  = adapt_en;
      p_ii_d = 36'($signed(xI)) * 36'($signed(econjI));
      p_qq_d = 36'($signed(xQ)) * 36'($signed(econjQ));
      p_iq_d = 36'($signed(xI)) * 36'($signed(econjQ));
      p_qi_d = 36'($signed(xQ)) * 36'($signed(econjI));

      v2_d   = v1_q;
      idx2_d = idx1_q;
      en2_d  = en1_q;
      r_i_d  = 37'(p_ii_q) - 37'(p_qq_q);
      r_q_d  = 37'(p_iq_q) + 37'(p_qi_q);

      // Weight read and writeback both happen here, so same-index beats never race.
      u_i   = r_i_q >>> SHIFT;
      u_q   = r_q_q >>> SHIFT;
      sum_i = 38'(w_i_q[idx2_q]) + 38'(u_i);
      sum_q = 38'(w_q_q[idx2_q]) + 38'(u_q);
      {clip_i, sat_i} = saturate(sum_i);
      {clip_q, sat_q} = saturate(sum_q);

      w_i_d  = w_i_q;
      w_q_d  = w_q_q;
      ov_d   = v2_q;
      oidx_d = oidx_q;
      owi_d  = owi_q;
      owq_d  = owq_q;
      osat_d = osat_q;
      if (v2_q) begin
         oidx_d = idx2_q;
         if (en2_q) begin
            owi_d          = sat_i;
            owq_d          = sat_q;
            osat_d         = clip_i | clip_q;
            w_i_d[idx2_q]  = sat_i;
            w_q_d[idx2_q]  = sat_q;
         end else begin
            owi_d  = w_i_q[idx2_q];
            owq_d  = w_q_q[idx2_q];
            osat_d = 1'b0;
         end
      end

      // Clear drops everything in flight, including a beat arriving this cycle.
      if (wclr) begin
         for (int k = 0; k < N_ELEM; k++) begin
            w_i_d[k] = INIT_I;
            w_q_d[k] = INIT_Q;
         end
         cnt_d = '0;
         v1_d  = 1'b0;
         v2_d  = 1'b0;
         ov_d  = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the weight array is a register file that must restart at WINIT, so it is reset explicitly.
         for (int k = 0; k < N_ELEM; k++) begin
            w_i_q[k] <= INIT_I;
            w_q_q[k] <= INIT_Q;
         end
         cnt_q  <= '0;
         v1_q   <= 1'b0;
         en1_q  <= 1'b0;
         idx1_q <= '0;
         p_ii_q <= '0;
         p_qq_q <= '0;
         p_iq_q <= '0;
         p_qi_q <= '0;
         v2_q   <= 1'b0;
         en2_q  <= 1'b0;
         idx2_q <= '0;
         r_i_q  <= '0;
         r_q_q  <= '0;
         ov_q   <= 1'b0;
         oidx_q <= '0;
         owi_q  <= '0;
         owq_q  <= '0;
         osat_q <= 1'b0;
      end else begin
         w_i_q  <= w_i_d;
         w_q_q  <= w_q_d;
         cnt_q  <= cnt_d;
         v1_q   <= v1_d;
         en1_q  <= en1_d;
         idx1_q <= idx1_d;
         p_ii_q <= p_ii_d;
         p_qq_q <= p_qq_d;
         p_iq_q <= p_iq_d;
         p_qi_q <= p_qi_d;
         v2_q   <= v2_d;
         en2_q  <= en2_d;
         idx2_q <= idx2_d;
         r_i_q  <= r_i_d;
         r_q_q  <= r_q_d;
         ov_q   <= ov_d;
         oidx_q <= oidx_d;
         owi_q  <= owi_d;
         owq_q  <= owq_d;
         osat_q <= osat_d;
      end
   end

   assign out_valid = ov_q;
   assign out_idx   = oidx_q;
   assign wI        = owi_q;
   assign wQ        = owq_q;
   assign sat_flag  = osat_q;

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed bench for lms_weight_update: hand-computed weight updates checked
// against a queue of expected output beats, cycle-exact on latency.
module tb_lms_weight_update;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, in_sof = 1'b0, adapt_en = 1'b0, wclr = 1'b0;
   logic [17:0] xI = '0, xQ = '0, econjI = '0, econjQ = '0;

   logic        ov, osat, ov0, osat0;
   logic [1:0]  oidx, oidx0;
   logic [17:0] owi, owq, owi0, owq0;

   lms_weight_update #(.N_ELEM(4), .IDX_W(2), .MU_SHIFT(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
      .xI(xI), .xQ(xQ), .econjI(econjI), .econjQ(econjQ),
      .adapt_en(adapt_en), .wclr(wclr),
      .out_valid(ov), .out_idx(oidx), .wI(owi), .wQ(owq), .sat_flag(osat)
   );

   // Second instance with mu = 1 exercises saturation.
   lms_weight_update #(.N_ELEM(4), .IDX_W(2), .MU_SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
      .xI(xI), .xQ(xQ), .econjI(econjI), .econjQ(econjQ),
      .adapt_en(adapt_en), .wclr(wclr),
      .out_valid(ov0), .out_idx(oidx0), .wI(owi0), .wQ(owq0), .sat_flag(osat0)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_fail = 0;

   task automatic check(input string tag, input int act, input int want);
      n_vec++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, want, $time);
      end
   endtask

   typedef struct {
      int due;
      int idx;
      int wi;
      int wq;
      int sat;
   } exp_t;

   exp_t exp_q[$];
   bit   mon_en = 1'b0;
   bit   mon_sel = 1'b0;

   logic m_v, m_sat;
   int   m_idx, m_wi, m_wq;
   bit   m_exp_v;
   exp_t m_e;

   // Every cycle: out_valid must be high exactly when a beat is due.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         m_v   = mon_sel ? ov0 : ov;
         m_idx = int'(mon_sel ? oidx0 : oidx);
         m_wi  = int'($signed(mon_sel ? owi0 : owi));
         m_wq  = int'($signed(mon_sel ? owq0 : owq));
         m_sat = mon_sel ? osat0 : osat;
         m_exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         check("out_valid", int'(m_v), int'(m_exp_v));
         if (m_exp_v) begin
            m_e = exp_q.pop_front();
            if (m_v) begin
               check("out_idx", m_idx, m_e.idx);
               check("wI", m_wi, m_e.wi);
               check("wQ", m_wq, m_e.wq);
               check("sat_flag", int'(m_sat), m_e.sat);
            end
         end
      end
   end

   task automatic beat(input logic sof, input int xi, input int xq, input int ei, input int eq,
                       input logic en, input bit chk,
                       input int e_idx, input int e_wi, input int e_wq, input int e_sat);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof;
      xI       = 18'(xi);
      xQ       = 18'(xq);
      econjI   = 18'(ei);
      econjQ   = 18'(eq);
      adapt_en = en;
      wclr     = 1'b0;
      if (chk) exp_q.push_back('{cyc + 3, e_idx, e_wi, e_wq, e_sat});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = 1'b0;
         wclr     = 1'b0;
      end
   endtask

   task automatic clear();
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      wclr     = 1'b1;
   endtask

   initial begin
      #3;
      check("rst_out_valid", int'(ov), 0);
      check("rst_out_idx", int'(oidx), 0);
      check("rst_wI", int'(owi), 0);
      check("rst_wQ", int'(owq), 0);
      check("rst_sat", int'(osat), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Basic update, cross terms, truncation toward -inf, wrap to index 0.
      beat(1, 65536, 0,     32768, 0,     1, 1, 0, 67584, 0,    0);
      beat(0, 0,     65536, 0,     32768, 1, 1, 1, 63488, 0,    0);
      beat(0, 65536, 0,     0,     32768, 1, 1, 2, 65536, 2048, 0);
      beat(0, 1,     0,     -1,    0,     1, 1, 3, 65535, 0,    0);
      beat(0, 1,     0,     1,     0,     1, 1, 0, 67584, 0,    0);
      idle(4);

      // Freeze: adapt_en=0 beats report the stored weight unchanged.
      beat(1, 65536, 0, 32768, 0, 0, 1, 0, 67584, 0,    0);
      beat(0, 65536, 0, 32768, 0, 1, 1, 1, 65536, 0,    0);
      beat(0, 65536, 0, 32768, 0, 0, 1, 2, 65536, 2048, 0);
      beat(0, 65536, 0, 32768, 0, 1, 1, 3, 67583, 0,    0);
      beat(0, 65536, 0, 32768, 0, 1, 1, 0, 69632, 0,    0);
      idle(4);

      // Ten-beat stream after a clear: each pass adds 2048 to every weight.
      clear();
      idle(1);
      for (int i = 0; i < 10; i++)
         beat(i == 0, 65536, 0, 32768, 0, 1, 1, i % 4, 65536 + 2048 * (i / 4 + 1), 0, 0);
      // Back-to-back updates of the same index.
      beat(1, 65536, 0, 32768, 0, 1, 1, 0, 73728, 0, 0);
      beat(1, 65536, 0, 32768, 0, 1, 1, 0, 75776, 0, 0);
      idle(4);

      // Clear with two beats in flight plus one in the clear cycle: all dropped.
      beat(1, 65536, 0, 32768, 0, 1, 0, 0, 0, 0, 0);
      beat(0, 65536, 0, 32768, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = 1'b0;
      wclr     = 1'b1;
      beat(0, 65536, 0, 32768, 0, 0, 1, 0, 65536, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b1;
      for (int k = 1; k < 4; k++)
         beat(0, 65536, 0, 32768, 0, 0, 1, k, 65536, 0, 0);
      idle(4);

      // Saturation on the mu = 1 instance.
      clear();
      idle(1);
      mon_sel = 1'b1;
      beat(1, 131071,  0, 131071, 0, 1, 1, 0, 131071,  0, 1);
      beat(1, 131071,  0, 131071, 0, 1, 1, 0, 131071,  0, 1);
      beat(1, -131071, 0, 131071, 0, 1, 1, 0, -131070, 0, 0);
      beat(1, -131071, 0, 131071, 0, 1, 1, 0, -131072, 0, 1);
      beat(1, -131071, 0, 131071, 0, 1, 1, 0, -131072, 0, 1);
      idle(4);
      mon_sel = 1'b0;

      // Asynchronous reset with beats in flight.
      mon_en = 1'b0;
      beat(1, 65536, 0, 32768, 0, 1, 0, 0, 0, 0, 0);
      beat(0, 65536, 0, 32768, 0, 1, 0, 0, 0, 0, 0);
      beat(0, 65536, 0, 32768, 0, 1, 0, 0, 0, 0, 0);
      idle(1);
      check("pre_rst_valid", int'(ov), 1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", int'(ov), 0);
      check("mid_rst_idx", int'(oidx), 0);
      check("mid_rst_wI", int'(owi), 0);
      check("mid_rst_wQ", int'(owq), 0);
      check("mid_rst_sat", int'(osat), 0);
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      beat(0, 65536, 0, 32768, 0, 0, 1, 0, 65536, 0, 0);
      idle(5);

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/lms_weight_update.md
Name: lms_weight_update

Overview:
- LMS weight-update stage for the adaptive beamformer. Sits directly downstream of the error/conjugate stage and consumes its conjugated, one-cycle-delayed error econj.
- Computes w[k] <= w[k] + mu * x[k] * econj for each antenna element k. The N_ELEM weights are time-multiplexed through one complex multiplier pipeline and held in a register array.
- Emits each updated weight with its element index for the beamformer combiner.

Parameters:
N_ELEM, 4, number of antenna elements/weights (2..16)
IDX_W, 2, width of element index (ceil(log2(N_ELEM)), min 1)
MU_SHIFT, 4, step size mu = 2^-MU_SHIFT (0..15)
WINIT_I, 65536, reset/clear value of every weight real part (1.0)
WINIT_Q, 0, reset/clear value of every weight imag part

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  x and econj valid this cycle
in_sof  in  1  first element of a snapshot; forces element index 0 for this beat
xI, xQ  in  18  signed element sample x[k]
econjI, econjQ  in  18  signed conjugated error, held by source for whole snapshot
adapt_en  in  1  1 = apply update, 0 = weights frozen (still output)
wclr  in  1  synchronous clear of all weights to WINIT
out_valid  out  1  wI/wQ/out_idx valid
out_idx  out  IDX_W  element index of output weight
wI, wQ  out  18  signed updated weight
sat_flag  out  1  saturation occurred on this output beat

Behaviour:
- Number format: all 18-bit data signed two's complement Q2.16 (1.0 = 65536, range [-2, 2)).
- Reset (rst_n=0, async):
  - all weights = WINIT_I/WINIT_Q
  - element counter = 0
  - pipeline valids = 0
  - out_valid = 0, out_idx = 0, wI = wQ = 0, sat_flag = 0
- Element counter:
  - The beat's index is 0 if in_sof=1, else the counter.
  - On each in_valid the counter becomes beat index + 1, wrapping at N_ELEM-1 -> 0.
  - Counter is unchanged when in_valid=0.
  - in_sof without in_valid is ignored.
- Pipeline, latency 3 cycles, throughput 1 beat/cycle, no backpressure:
  - S1: register the four 36-bit products xI*eI, xQ*eQ, xI*eQ, xQ*eI, plus the index and adapt_en.
  - S2: register rI = xI*eI - xQ*eQ and rQ = xI*eQ + xQ*eI, 37-bit, full precision.
  - S2 step: uI/uQ = r >>> (16+MU_SHIFT). This is an arithmetic shift that truncates toward -inf; no rounding.
  - S3: read w[idx], form the sum w + u in wide precision, and saturate to [-131072, 131071]. Saturation is per component.
  - S3 writeback: if adapt_en (as sampled at S1) is set, write the result back to w[idx] and output it. Otherwise leave w[idx] unchanged and output the unchanged w[idx].
- out_valid is asserted exactly 3 cycles after the accepted in_valid.
- Weight read and write both occur in S3, so back-to-back updates to the same index are hazard-free for any N_ELEM.
- sat_flag = 1 on an output beat if either component clipped. It is 0 when adapt_en=0.
- Outputs hold their last values when out_valid=0.
- wclr has priority over everything:
  - On that edge, all weights = WINIT.
  - All pipeline valids cleared; in-flight beats are dropped with no output and no writeback.
  - Element counter = 0.
  - An in_valid beat in the same cycle as wclr is dropped.
- Reset mid-operation: same as wclr, but asynchronous, and the outputs are zeroed.

Test Plan:
- Reset then single update: MU_SHIFT=4, in_sof=1, x=(65536,0), econj=(32768,0), adapt_en=1 -> 3 cycles later out_valid=1, out_idx=0, wI=67584, wQ=0, sat_flag=0.
- Complex cross terms: k=1, x=(0,65536), econj=(0,32768), weight at init -> product real -0.5, wI=65536-2048=63488, wQ=0. Then x=(65536,0), econj=(0,32768) -> wQ=2048.
- Truncation toward -inf: xI=1, eI=-1, other inputs 0 -> uI=-1, wI=65535. Same with eI=+1 -> uI=0, wI=65536.
- Saturation: repeat x=(131071,0), econj=(131071,0), MU_SHIFT=0 on element 0 -> wI climbs and pins at 131071 with sat_flag=1. Mirror with negative x -> pins at -131072.
- Streaming/wrap and freeze:
  - N_ELEM=4, 10 consecutive beats, in_sof on the first only -> out_idx sequence 0,1,2,3,0,1,2,3,0,1, with each weight updated once per pass.
  - Toggle adapt_en=0 mid-stream -> those beats output unchanged weights.
- wclr mid-stream with 2 beats in flight -> those beats produce no out_valid, all weights read back as 65536/0, and the next beat (no in_sof) gets index 0. Assert rst_n low mid-stream -> outputs immediately 0 and out_valid=0.
